// File: rtl/diag_severity_ctrl.sv
// Diagnostic severity controller: per-code severity map with push/pop save stack,
// event classification and saturating counters. Optional macro: DIAG_FATAL_HALT_EN.
module diag_severity_ctrl #(
    parameter int unsigned NUM_CODES = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned CODE_W   = $clog2(NUM_CODES),
    localparam int unsigned DEPTH_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CODE_W-1:0]  cmd_code,
    input  logic [1:0]         cmd_sev,
    input  logic               evt_valid,
    input  logic [CODE_W-1:0]  evt_code,
    output logic               out_valid,
    output logic [CODE_W-1:0]  out_code,
    output logic [1:0]         out_sev,
    output logic [CNT_W-1:0]   warn_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   sup_cnt,
    output logic               fatal,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAP_W   = 2 * NUM_CODES;

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpPush = 2'd1;
    localparam logic [1:0] OpPop  = 2'd2;
    localparam logic [1:0] OpSet  = 2'd3;

    localparam logic [1:0] SevIgnore = 2'd0;
    localparam logic [1:0] SevWarn   = 2'd1;
    localparam logic [1:0] SevError  = 2'd2;
    localparam logic [1:0] SevFatal  = 2'd3;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e           state_q;
    logic [MAP_W-1:0] map_q;
    logic [MAP_W-1:0] map_d;
    logic [MAP_W-1:0] stack_q [DEPTH];

    logic             cmd_fire;
    logic             push_en;
    logic             pop_en;
    logic             ovf_set;
    logic             unf_set;
    logic             evt_take;
    logic [1:0]       evt_sev;
    logic [PTR_W-1:0] push_ptr;
    logic [PTR_W-1:0] pop_ptr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef DIAG_FATAL_HALT_EN
    assign cmd_ready = (state_q == StRun);
`else
    assign cmd_ready = 1'b1;
`endif

    assign cmd_fire = cmd_valid && cmd_ready;
    assign evt_take = evt_valid && (state_q == StRun);
    assign push_ptr = stack_depth[PTR_W-1:0];
    assign pop_ptr  = PTR_W'(stack_depth - DEPTH_W'(1));

    // Codes outside the map default to error.
    always_comb begin
        evt_sev = SevError;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (evt_code == CODE_W'(i)) evt_sev = map_q[2*i +: 2];
        end
    end

    always_comb begin
        map_d   = map_q;
        push_en = 1'b0;
        pop_en  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (cmd_fire) begin
            case (cmd_op)
                OpPush: begin
                    if (stack_depth == DEPTH_W'(DEPTH)) ovf_set = 1'b1;
                    else                                push_en = 1'b1;
                end
                OpPop: begin
                    if (stack_depth == '0) begin
                        unf_set = 1'b1;
                    end else begin
                        pop_en = 1'b1;
                        map_d  = stack_q[pop_ptr];
                    end
                end
                OpSet: begin
                    for (int i = 0; i < NUM_CODES; i++) begin
                        if (cmd_code == CODE_W'(i)) map_d[2*i +: 2] = cmd_sev;
                    end
                end
                OpNop: ;
                default: ;
            endcase
        end
    end

    // Stack storage needs no reset; its contents are meaningless above stack_depth.
    always_ff @(posedge clk) begin
        if (!rst && push_en) stack_q[push_ptr] <= map_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            map_q       <= {NUM_CODES{SevWarn}};
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_sev     <= '0;
            warn_cnt    <= '0;
            err_cnt     <= '0;
            sup_cnt     <= '0;
            fatal       <= 1'b0;
            stack_depth <= '0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
        end else begin
            map_q     <= map_d;
            out_valid <= 1'b0;
            if (push_en) stack_depth <= stack_depth + DEPTH_W'(1);
            if (pop_en)  stack_depth <= stack_depth - DEPTH_W'(1);
            if (ovf_set) stack_ovf <= 1'b1;
            if (unf_set) stack_unf <= 1'b1;
            if (evt_take) begin
                case (evt_sev)
                    SevIgnore: sup_cnt <= sat_inc(sup_cnt);
                    SevWarn: begin
                        warn_cnt  <= sat_inc(warn_cnt);
                        out_valid <= 1'b1;
                        out_code  <= evt_code;
                        out_sev   <= SevWarn;
                    end
                    SevError: begin
                        err_cnt   <= sat_inc(err_cnt);
                        out_valid <= 1'b1;
                        out_code  <= evt_code;
                        out_sev   <= SevError;
                    end
                    SevFatal: begin
                        out_valid <= 1'b1;
                        out_code  <= evt_code;
`ifdef DIAG_FATAL_HALT_EN
                        out_sev   <= SevFatal;
                        fatal     <= 1'b1;
                        state_q   <= StHalt;
`else
                        out_sev   <= SevError;
                        err_cnt   <= sat_inc(err_cnt);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
